// File: rtl/uart_alu_intf_pkg.sv
// -----------------------------------------------------------------------------
// uart_alu_intf_pkg
//   Definitions shared by the UART command endpoint, the ALU it drives and the
//   benches that exercise both:
//     - state_e     : command FSM state encoding
//     - ALU_*       : 6-bit ALU opcode constants
//     - DEF_*       : default widths/limits for the endpoint
//     - in_command(): true while a partially received command is in flight
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_alu_intf_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_OP_WIDTH       = 6;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    LATCH   = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_e;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SRA = 6'b000011;
  localparam logic [5:0] ALU_SRL = 6'b000010;
  localparam logic [5:0] ALU_NOR = 6'b100111;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_command(input state_e s);
    return (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_intf.sv
// -----------------------------------------------------------------------------
// uart_alu_intf
//   Byte-level command endpoint behind a uart_rx/uart_tx pair. Three received
//   bytes form one command (operand A, operand B, opcode); they are held on the
//   ALU operand ports, the ALU result is captured and sent back through the
//   transmitter. A partial command is aborted if the next byte does not arrive
//   within TIMEOUT_CYCLES clocks.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high
//   i_rx_done     in   1-cycle pulse: i_rx_data valid
//   i_rx_data     in   received byte
//   i_tx_done     in   1-cycle pulse: transmitter finished its frame
//   i_alu_result  in   combinational ALU result for o_alu_a/b/op
//   o_alu_a       out  operand A register
//   o_alu_b       out  operand B register
//   o_alu_op      out  opcode register (low OP_WIDTH bits of third byte)
//   o_tx_start    out  1-cycle start pulse to the transmitter
//   o_tx_data     out  byte to transmit, stable from start until i_tx_done
//   o_busy        out  high in every state except GET_A
//   o_drop        out  1-cycle pulse: a received byte was discarded
//   o_timeout     out  1-cycle pulse: a partial command was aborted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_alu_intf
  import uart_alu_intf_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OP_WIDTH       = DEF_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_drop,
  output logic                  o_timeout
);

  // A limit of 1 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  drop_q, drop_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  expired;

  // The counter never passes CNT_LAST: on that value the FSM either accepts
  // a byte (clear) or aborts to GET_A (clear), so it cannot wrap.
  assign expired = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      GET_A: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          cnt_d   = '0;          // fresh window on entry to GET_B
          state_d = GET_B;
        end
      end

      GET_B: begin
        // A byte on the expiry cycle still wins over the timeout.
        if (i_rx_done) begin
          b_d     = i_rx_data;
          cnt_d   = '0;
          state_d = GET_OP;
        end else if (expired) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GET_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[OP_WIDTH-1:0];
          cnt_d   = '0;
          state_d = LATCH;
        end else if (expired) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LATCH: begin
        // Operands have been on the ALU ports for a full cycle by now.
        tx_data_d = i_alu_result;
        drop_d    = i_rx_done;
        state_d   = SEND;
      end

      SEND: begin
        // Registered, so the pulse lines up with the first WAIT_TX cycle.
        tx_start_d = 1'b1;
        drop_d     = i_rx_done;
        state_d    = WAIT_TX;
      end

      WAIT_TX: begin
        drop_d = i_rx_done;
        if (i_tx_done) begin
          state_d = GET_A;
        end
      end

      default: begin
        state_d = GET_A;
      end
    endcase
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = (state_q != GET_A);

endmodule

// File: tb/tb_uart_alu_intf.sv
`timescale 1ns/1ps

module tb_uart_alu_intf;
  import uart_alu_intf_pkg::*;

  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_rx_done;
  logic [DW-1:0] i_rx_data;
  logic          i_tx_done;
  logic [DW-1:0] i_alu_result;
  logic [DW-1:0] o_alu_a;
  logic [DW-1:0] o_alu_b;
  logic [OW-1:0] o_alu_op;
  logic          o_tx_start;
  logic [DW-1:0] o_tx_data;
  logic          o_busy;
  logic          o_drop;
  logic          o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt   = 0;
  int timeout_cnt = 0;
  logic [DW-1:0] exp_q[$];

  uart_alu_intf #(
    .DATA_WIDTH    (DW),
    .OP_WIDTH      (OW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rx_done   (i_rx_done),
    .i_rx_data   (i_rx_data),
    .i_tx_done   (i_tx_done),
    .i_alu_result(i_alu_result),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_drop      (o_drop),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  // External ALU behaviour.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    logic [DW-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SRA: r = DW'($signed(a) >>> b[2:0]);
      ALU_SRL: r = a >> b[2:0];
      ALU_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb i_alu_result = alu_fn(o_alu_a, o_alu_b, o_alu_op);

  always @(negedge clk) begin
    if (o_tx_start) start_cnt++;
    if (o_timeout)  timeout_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus-only helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [DW-1:0] d);
    i_rx_data = d;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic send_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] opb);
    exp_q.push_back(alu_fn(a, b, opb[OW-1:0]));
    rx_byte(a);
    rx_byte(b);
    rx_byte(opb);
  endtask

  // Counts ticks after the last rx byte until o_tx_start is seen (bounded).
  task automatic wait_start(output int lat);
    lat = 0;
    while (!o_tx_start && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Waits for the start pulse, records it, then completes the frame.
  task automatic run_tx(output int lat, output logic seen, output logic [DW-1:0] data);
    wait_start(lat);
    seen = o_tx_start;
    data = o_tx_data;
    repeat (2) tick();
    tx_done_pulse();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data} !== '0) begin
      $display("FAIL reset_regs: got a=%h b=%h op=%h tx=%h, expected all 0", o_alu_a, o_alu_b, o_alu_op, o_tx_data);
      n_fail++;
    end
    n_checks++;
    if ({o_tx_start, o_busy, o_drop, o_timeout} !== 4'b0000) begin
      $display("FAIL reset_flags: got start/busy/drop/timeout=%b, expected 0000",
               {o_tx_start, o_busy, o_drop, o_timeout});
      n_fail++;
    end
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b0 || start_cnt != 0) begin
      $display("FAIL reset_idle: got busy=%b starts=%0d, expected busy=0 starts=0", o_busy, start_cnt);
      n_fail++;
    end
  endtask

  task automatic test_add();
    int lat;
    logic [DW-1:0] exp;
    send_cmd(8'h05, 8'h03, 8'h20);
    wait_start(lat);
    n_checks++;
    if (o_tx_start !== 1'b1 || lat + 1 != 3) begin
      $display("FAIL add_latency: got start=%b after %0d cycles, expected start=1 after 3", o_tx_start, lat + 1);
      n_fail++;
    end
    n_checks++;
    if (o_alu_a !== 8'h05 || o_alu_b !== 8'h03 || o_alu_op !== 6'h20) begin
      $display("FAIL add_operands: got a=%h b=%h op=%h, expected a=05 b=03 op=20", o_alu_a, o_alu_b, o_alu_op);
      n_fail++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (o_tx_data !== exp || o_tx_data !== 8'h08) begin
      $display("FAIL add_result: got %h, expected %h", o_tx_data, exp);
      n_fail++;
    end
    tick();
    n_checks++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      $display("FAIL add_pulse: got start=%b busy=%b, expected start=0 busy=1", o_tx_start, o_busy);
      n_fail++;
    end
    repeat (3) tick();
    tx_done_pulse();
    n_checks++;
    if (o_busy !== 1'b0 || start_cnt != 1) begin
      $display("FAIL add_done: got busy=%b starts=%0d, expected busy=0 starts=1", o_busy, start_cnt);
      n_fail++;
    end
  endtask

  task automatic test_sub();
    int lat;
    logic seen;
    logic [DW-1:0] data, exp;
    send_cmd(8'h03, 8'h05, 8'hE2);
    n_checks++;
    if (o_alu_op !== 6'h22) begin
      $display("FAIL sub_opcode: got %h, expected 22", o_alu_op);
      n_fail++;
    end
    run_tx(lat, seen, data);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (seen !== 1'b1 || data !== exp || data !== 8'hFE) begin
      $display("FAIL sub_result: got start=%b data=%h, expected start=1 data=%h", seen, data, exp);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int n, lat, t0;
    logic seen;
    logic [DW-1:0] data, exp;
    t0 = timeout_cnt;
    rx_byte(8'h11);
    n = 0;
    while (!o_timeout && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (o_timeout !== 1'b1 || n != TO) begin
      $display("FAIL timeout_delay: got timeout=%b after %0d cycles, expected 1 after %0d", o_timeout, n, TO);
      n_fail++;
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_alu_a !== 8'h11) begin
      $display("FAIL timeout_state: got busy=%b a=%h, expected busy=0 a=11", o_busy, o_alu_a);
      n_fail++;
    end
    tick();
    n_checks++;
    if (o_timeout !== 1'b0 || timeout_cnt != t0 + 1) begin
      $display("FAIL timeout_pulse: got timeout=%b count=%0d, expected 0 and %0d", o_timeout, timeout_cnt, t0 + 1);
      n_fail++;
    end
    // Fresh command after the abort.
    send_cmd(8'h07, 8'h02, {2'b00, ALU_ADD});
    run_tx(lat, seen, data);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (seen !== 1'b1 || data !== exp) begin
      $display("FAIL timeout_fresh: got start=%b data=%h, expected start=1 data=%h", seen, data, exp);
      n_fail++;
    end
    // Bytes landing exactly on the expiry cycle are accepted.
    t0 = timeout_cnt;
    exp_q.push_back(alu_fn(8'h21, 8'h04, ALU_OR));
    rx_byte(8'h21);
    repeat (TO - 1) tick();
    rx_byte(8'h04);
    n_checks++;
    if (o_busy !== 1'b1 || o_alu_b !== 8'h04) begin
      $display("FAIL expiry_b: got busy=%b b=%h, expected busy=1 b=04", o_busy, o_alu_b);
      n_fail++;
    end
    repeat (TO - 1) tick();
    rx_byte({2'b11, ALU_OR});
    run_tx(lat, seen, data);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (seen !== 1'b1 || data !== exp || timeout_cnt != t0) begin
      $display("FAIL expiry_accept: got start=%b data=%h timeouts=%0d, expected start=1 data=%h timeouts=%0d",
               seen, data, timeout_cnt - t0, exp, 0);
      n_fail++;
    end
  endtask

  task automatic test_drop();
    int lat, s0;
    logic [DW-1:0] data, exp;
    s0 = start_cnt;
    send_cmd(8'h0F, 8'hF0, {2'b00, ALU_XOR});
    wait_start(lat);
    data = o_tx_data;
    tick();
    rx_byte(8'hAA);
    n_checks++;
    if (o_drop !== 1'b1 || o_busy !== 1'b1) begin
      $display("FAIL drop_pulse: got drop=%b busy=%b, expected drop=1 busy=1", o_drop, o_busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (o_drop !== 1'b0 || o_tx_data !== data) begin
      $display("FAIL drop_hold: got drop=%b tx=%h, expected drop=0 tx=%h", o_drop, o_tx_data, data);
      n_fail++;
    end
    tx_done_pulse();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (start_cnt != s0 + 1 || data !== exp || o_busy !== 1'b0) begin
      $display("FAIL drop_single: got starts=%0d data=%h busy=%b, expected starts=1 data=%h busy=0",
               start_cnt - s0, data, o_busy, exp);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, s0;
    logic seen;
    logic [DW-1:0] data, exp;
    send_cmd(8'h80, 8'h02, {2'b00, ALU_SRA});
    wait_start(lat);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (o_tx_data !== exp) begin
      $display("FAIL rst_wait_data: got %h, expected %h", o_tx_data, exp);
      n_fail++;
    end
    tick();
    s0 = start_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_tx_data !== 8'h00) begin
      $display("FAIL rst_wait_tx: got busy=%b tx=%h, expected busy=0 tx=00", o_busy, o_tx_data);
      n_fail++;
    end
    rx_byte(8'h01);
    rx_byte(8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_alu_a !== 8'h00 || o_alu_b !== 8'h00) begin
      $display("FAIL rst_get_op: got busy=%b a=%h b=%h, expected busy=0 a=00 b=00", o_busy, o_alu_a, o_alu_b);
      n_fail++;
    end
    repeat (6) tick();
    n_checks++;
    if (start_cnt != s0) begin
      $display("FAIL rst_no_start: got %0d starts, expected 0", start_cnt - s0);
      n_fail++;
    end
    send_cmd(8'h90, 8'h03, {2'b00, ALU_SRL});
    run_tx(lat, seen, data);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++;
    if (seen !== 1'b1 || data !== exp || lat + 1 != 3) begin
      $display("FAIL rst_recover: got start=%b data=%h lat=%0d, expected start=1 data=%h lat=3",
               seen, data, lat + 1, exp);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] ops [8];
    logic [DW-1:0] a, b, data, exp;
    logic [1:0] hi;
    logic [OW-1:0] op;
    logic seen;
    int lat;
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_AND; ops[3] = ALU_OR;
    ops[4] = ALU_XOR; ops[5] = ALU_SRA; ops[6] = ALU_SRL; ops[7] = ALU_NOR;
    for (int i = 0; i < 8; i++) begin
      a  = DW'($urandom_range(0, 255));
      b  = DW'($urandom_range(0, 255));
      hi = 2'($urandom_range(0, 3));
      op = ops[i];
      exp_q.push_back(alu_fn(a, b, op));
      rx_byte(a);
      tx_done_pulse();            // ignored outside WAIT_TX
      rx_byte(b);
      rx_byte({hi, op});
      run_tx(lat, seen, data);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (seen !== 1'b1 || data !== exp || o_alu_op !== op) begin
        $display("FAIL b2b_%0d: got start=%b data=%h op=%h, expected start=1 data=%h op=%h",
                 i, seen, data, o_alu_op, exp, op);
        n_fail++;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    i_tx_done = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
      n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
